display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit segment display.
- Holds one 4-bit value per digit and shares a single external bcd_to_seg converter between all digits.
- Presents one digit's value to the converter at a time, registers the returned segment pattern, and drives a one-hot digit enable.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the register/bus logic that loads digit values and the display pins.

---
 rtl/display_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit segment display.
// One 4-bit value per digit is held in a small bank. A single external
// converter is shared between all digits: the value of the digit under the
// scan pointer is presented on conv_bcd. The returned pattern is registered
// onto seg_out together with a one-hot digit enable. Blank gap cycles
// between digits suppress ghosting.
//
// scan_state exposes the FSM state (0 = IDLE, 1 = DISPLAY, 2 = GAP).
// The load port is a plain write strobe with no handshake: a write happens
// on every clock edge where load_en=1 and load_idx addresses an existing digit.
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 2,
    parameter int SCAN_DIV   = 1000,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [3:0]            load_val,
    output logic [3:0]            conv_bcd,
    input  logic [7:0]            conv_seg,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done,
    output logic [1:0]            scan_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DISPLAY = 2'd1;
    localparam logic [1:0] ST_GAP     = 2'd2;

    localparam logic [IDX_W-1:0] LAST_PTR  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W:0]   NUM_D     = (IDX_W + 1)'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    // With GAP_CYCLES=0 this value is never compared against: GAP is never entered.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

    logic [3:0]       val [NUM_DIGITS];
    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [CNT_W-1:0] cnt;
    logic             load_ok;
    logic             slot_end;

    assign scan_state = state;
    assign conv_bcd   = val[ptr];
    assign load_ok    = load_en && ({1'b0, load_idx} < NUM_D);
    assign ptr_next   = (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    assign slot_end   = (state == ST_DISPLAY) && (cnt == SCAN_LAST);

    // Digit value bank: cleared by reset, written whenever a valid index is strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                val[i] <= 4'd0;
            end
        end else if (load_ok) begin
            val[load_idx] <= load_val;
        end
    end

    // Scan FSM: walks DISPLAY/GAP slots; dropping enable abandons the slot.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_DISPLAY;
                    ptr   <= '0;
                    cnt   <= '0;
                end
                ST_DISPLAY: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (HAS_GAP) begin
                            state <= ST_GAP;
                        end else begin
                            ptr <= ptr_next;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        ptr   <= ptr_next;
                        state <= ST_DISPLAY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output registers: pattern and enable of the digit displayed last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= 8'h00;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            if (state == ST_DISPLAY) begin
                seg_out  <= conv_seg;
                digit_en <= NUM_DIGITS'(1) << ptr;
            end else begin
                seg_out  <= 8'h00;
                digit_en <= '0;
            end
            frame_done <= enable && slot_end && (ptr == LAST_PTR);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a 4-digit and a 3-digit instance
// (SCAN_DIV=4, GAP_CYCLES=1) share clock, reset, enable and load signals.
// The external converter is modelled as value -> two decimal digits
// (e.g. 12 -> 0x12) so each digit's pattern is easy to recognise.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       load_en;
  logic [1:0] load_idx;
  logic [3:0] load_val;

  logic [3:0] conv_bcd4, conv_bcd3;
  logic [7:0] conv_seg4, conv_seg3;
  logic [7:0] seg_out4, seg_out3;
  logic [3:0] digit_en4;
  logic [2:0] digit_en3;
  logic       frame_done4, frame_done3;
  logic [1:0] scan_state4, scan_state3;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  logic [3:0] exp4 [4];
  logic [3:0] exp3 [3];

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [7:0] seg_model(input logic [3:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v / 4'd10;
    ones = v % 4'd10;
    return {tens, ones};
  endfunction

  assign conv_seg4 = seg_model(conv_bcd4);
  assign conv_seg3 = seg_model(conv_bcd3);

  display_scan_ctrl #(
    .NUM_DIGITS(4), .IDX_W(2), .SCAN_DIV(4), .GAP_CYCLES(1), .CNT_W(16)
  ) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .load_en(load_en),
    .load_idx(load_idx), .load_val(load_val), .conv_bcd(conv_bcd4),
    .conv_seg(conv_seg4), .seg_out(seg_out4), .digit_en(digit_en4),
    .frame_done(frame_done4), .scan_state(scan_state4)
  );

  display_scan_ctrl #(
    .NUM_DIGITS(3), .IDX_W(2), .SCAN_DIV(4), .GAP_CYCLES(1), .CNT_W(16)
  ) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .load_en(load_en),
    .load_idx(load_idx), .load_val(load_val), .conv_bcd(conv_bcd3),
    .conv_seg(conv_seg3), .seg_out(seg_out3), .digit_en(digit_en3),
    .frame_done(frame_done3), .scan_state(scan_state3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n edges while scanning; k counts edges since the scan entered DISPLAY.
  // Each digit slot is 4 shown cycles plus 1 blank cycle.
  task automatic run_cycles(input int n);
    int f, slot, pos;
    logic [3:0] de4;
    logic [2:0] de3;
    logic [7:0] sg;
    for (int i = 0; i < n; i++) begin
      step();
      f = k % 20; slot = f / 5; pos = f % 5;
      de4 = 4'b0001 << slot;
      sg  = seg_model(exp4[slot]);
      check_eq("digit_en4", digit_en4, (pos < 4) ? de4 : 4'b0000);
      check_eq("seg_out4", seg_out4, (pos < 4) ? sg : 8'h00);
      check_eq("frame_done4", frame_done4, (f == 18) ? 1 : 0);
      f = k % 15; slot = f / 5; pos = f % 5;
      de3 = 3'b001 << slot;
      sg  = seg_model(exp3[slot]);
      check_eq("digit_en3", digit_en3, (pos < 4) ? de3 : 3'b000);
      check_eq("seg_out3", seg_out3, (pos < 4) ? sg : 8'h00);
      check_eq("frame_done3", frame_done3, (f == 13) ? 1 : 0);
      k++;
    end
  endtask

  task automatic load(input logic [1:0] idx, input logic [3:0] v);
    load_en  = 1'b1;
    load_idx = idx;
    load_val = v;
    step();
    load_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load_en = 1'b0; load_idx = 2'd0; load_val = 4'd0;
    for (int i = 0; i < 4; i++) exp4[i] = 4'd0;
    for (int i = 0; i < 3; i++) exp3[i] = 4'd0;

    // 1. reset state with enable held high
    step(); step();
    check_eq("rst_seg", seg_out4, 8'h00);
    check_eq("rst_digit_en", digit_en4, 4'b0000);
    check_eq("rst_frame_done", frame_done4, 1'b0);
    check_eq("rst_conv_bcd", conv_bcd4, 4'd0);
    check_eq("rst_state", scan_state4, 2'd0);
    rst = 1'b0;
    step();
    check_eq("enter_display", scan_state4, 2'd1);
    check_eq("enter_digit_en", digit_en4, 4'b0000);
    enable = 1'b0;
    step();
    check_eq("first_digit_en", digit_en4, 4'b0001);
    check_eq("disable_state", scan_state4, 2'd0);
    step();
    check_eq("disable_digit_en", digit_en4, 4'b0000);

    // 2. load values while dark (idx 3 is out of range for the 3-digit unit)
    load(2'd3, 4'd7);
    load(2'd0, 4'd3);
    load(2'd1, 4'd9);
    load(2'd2, 4'd12);
    load(2'd3, 4'd15);
    check_eq("dark_conv_bcd", conv_bcd4, 4'd3);
    check_eq("dark_seg", seg_out4, 8'h00);
    exp4[0] = 4'd3; exp4[1] = 4'd9; exp4[2] = 4'd12; exp4[3] = 4'd15;
    exp3[0] = 4'd3; exp3[1] = 4'd9; exp3[2] = 4'd12;
    enable = 1'b1;
    step();
    check_eq("reenter_display", scan_state4, 2'd1);
    k = 0;
    run_cycles(40);

    // 3. rewrite digit 1 while it is displayed
    run_cycles(5);
    load_en = 1'b1; load_idx = 2'd1; load_val = 4'd10;
    run_cycles(1);
    load_en = 1'b0;
    check_eq("live_conv_bcd", conv_bcd4, 4'd10);
    exp4[1] = 4'd10; exp3[1] = 4'd10;
    run_cycles(14);
    run_cycles(20);

    // 4. drop enable mid-slot on digit 2
    run_cycles(11);
    enable = 1'b0;
    step();
    check_eq("drop_state", scan_state4, 2'd0);
    check_eq("drop_digit_en", digit_en4, 4'b0100);
    check_eq("drop_seg", seg_out4, 8'h12);
    step();
    check_eq("dark_digit_en", digit_en4, 4'b0000);
    check_eq("dark_seg2", seg_out4, 8'h00);
    check_eq("dark_digit_en3", digit_en3, 3'b000);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("dark_frame_done", frame_done4, 1'b0);
      check_eq("dark_frame_done3", frame_done3, 1'b0);
    end
    enable = 1'b1;
    step();
    check_eq("restart_state", scan_state4, 2'd1);
    k = 0;
    run_cycles(20);

    // 6. reset mid-frame with a simultaneous load
    run_cycles(7);
    rst = 1'b1; load_en = 1'b1; load_idx = 2'd2; load_val = 4'd5;
    step();
    rst = 1'b0; load_en = 1'b0;
    check_eq("mid_rst_conv_bcd", conv_bcd4, 4'd0);
    check_eq("mid_rst_seg", seg_out4, 8'h00);
    check_eq("mid_rst_digit_en", digit_en4, 4'b0000);
    check_eq("mid_rst_frame_done", frame_done4, 1'b0);
    check_eq("mid_rst_state", scan_state4, 2'd0);
    for (int i = 0; i < 4; i++) exp4[i] = 4'd0;
    for (int i = 0; i < 3; i++) exp3[i] = 4'd0;
    step();
    check_eq("post_rst_state", scan_state4, 2'd1);
    k = 0;
    run_cycles(20);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
